// File: rtl/aes_avalon_regs.sv
// Avalon-MM register bank in front of the AES decryption core: key/ciphertext in, plaintext/status/cycle count out.
// 1-cycle registered reads, writes land on the edge; no backpressure (slave is always ready).
module aes_avalon_regs (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         AVL_CS,
    input  logic         AVL_READ,
    input  logic         AVL_WRITE,
    input  logic [3:0]   AVL_ADDR,
    input  logic [3:0]   AVL_BYTE_EN,
    input  logic [31:0]  AVL_WRITEDATA,
    output logic [31:0]  AVL_READDATA,
    output logic [31:0]  EXPORT_DATA,
    output logic [127:0] AES_KEY,
    output logic [127:0] AES_MSG_ENC,
    output logic         AES_START,
    input  logic         AES_DONE,
    input  logic [127:0] AES_MSG_DEC
);

    // Bit 0 of the encoding is AES_START itself, so the output is a plain flop bit.
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b11,
        S_DONE = 2'b01
    } state_t;

    state_t      r_state;
    logic [31:0] r_key [4];
    logic [31:0] r_enc [4];
    logic [31:0] r_dec [4];
    logic [31:0] r_scratch;
    logic [31:0] r_count;
    logic [31:0] r_start;
    logic        r_done_flag;
    logic [31:0] r_readdata;

    logic        w_wr;
    logic        w_rd;
    logic        w_locked;
    logic        w_go;
    logic        w_stop;
    logic [31:0] w_rdata;

    function automatic logic [31:0] merge(input logic [31:0] old_val,
                                          input logic [31:0] new_val,
                                          input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

    assign w_wr     = AVL_CS & AVL_WRITE;
    assign w_rd     = AVL_CS & AVL_READ;
    assign w_locked = (r_state == S_RUN);
    assign w_go     = w_wr && (AVL_ADDR == 4'd14) && AVL_BYTE_EN[0] && AVL_WRITEDATA[0]
                      && (r_state == S_IDLE);
    assign w_stop   = w_wr && (AVL_ADDR == 4'd14) && AVL_BYTE_EN[0] && !AVL_WRITEDATA[0]
                      && (r_state == S_DONE);

    always_comb begin
        w_rdata = '0;
        case (AVL_ADDR[3:2])
            2'd0: w_rdata = r_key[AVL_ADDR[1:0]];
            2'd1: w_rdata = r_enc[AVL_ADDR[1:0]];
            2'd2: w_rdata = r_dec[AVL_ADDR[1:0]];
            default: begin
                case (AVL_ADDR[1:0])
                    2'd0:    w_rdata = r_scratch;
                    2'd1:    w_rdata = r_count;
                    2'd2:    w_rdata = r_start;
                    default: w_rdata = {31'b0, r_done_flag};
                endcase
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state     <= S_IDLE;
            r_scratch   <= '0;
            r_count     <= '0;
            r_start     <= '0;
            r_done_flag <= 1'b0;
            r_readdata  <= '0;
            for (int i = 0; i < 4; i++) begin
                r_key[i] <= '0;
                r_enc[i] <= '0;
                r_dec[i] <= '0;
            end
        end else begin
            if (w_rd) r_readdata <= w_rdata;

            if (w_wr && !w_locked) begin
                if (AVL_ADDR[3:2] == 2'd0)
                    r_key[AVL_ADDR[1:0]] <= merge(r_key[AVL_ADDR[1:0]], AVL_WRITEDATA, AVL_BYTE_EN);
                if (AVL_ADDR[3:2] == 2'd1)
                    r_enc[AVL_ADDR[1:0]] <= merge(r_enc[AVL_ADDR[1:0]], AVL_WRITEDATA, AVL_BYTE_EN);
                if (AVL_ADDR == 4'd14)
                    r_start <= merge(r_start, AVL_WRITEDATA, AVL_BYTE_EN);
            end
            if (w_wr && (AVL_ADDR == 4'd12))
                r_scratch <= merge(r_scratch, AVL_WRITEDATA, AVL_BYTE_EN);

            case (r_state)
                S_IDLE: begin
                    if (w_go) begin
                        r_state <= S_RUN;
                        r_count <= '0;
                    end
                end
                S_RUN: begin
                    if (r_count != 32'hFFFF_FFFF) r_count <= r_count + 32'd1;
                    if (AES_DONE) begin
                        r_dec[0]    <= AES_MSG_DEC[127:96];
                        r_dec[1]    <= AES_MSG_DEC[95:64];
                        r_dec[2]    <= AES_MSG_DEC[63:32];
                        r_dec[3]    <= AES_MSG_DEC[31:0];
                        r_done_flag <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (w_stop) begin
                        r_state     <= S_IDLE;
                        r_done_flag <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign AVL_READDATA = r_readdata;
    assign AES_START    = r_state[0];
    assign AES_KEY      = {r_key[0], r_key[1], r_key[2], r_key[3]};
    assign AES_MSG_ENC  = {r_enc[0], r_enc[1], r_enc[2], r_enc[3]};
    assign EXPORT_DATA  = {r_key[0][31:16], r_key[3][15:0]};

endmodule

// File: tb/tb_aes_avalon_regs.sv
// Directed bench for aes_avalon_regs; the bench plays the NIOS master and the AES core.
module tb_aes_avalon_regs;

    logic         CLK;
    logic         RESET;
    logic         AVL_CS;
    logic         AVL_READ;
    logic         AVL_WRITE;
    logic [3:0]   AVL_ADDR;
    logic [3:0]   AVL_BYTE_EN;
    logic [31:0]  AVL_WRITEDATA;
    logic [31:0]  AVL_READDATA;
    logic [31:0]  EXPORT_DATA;
    logic [127:0] AES_KEY;
    logic [127:0] AES_MSG_ENC;
    logic         AES_START;
    logic         AES_DONE;
    logic [127:0] AES_MSG_DEC;

    localparam logic [127:0] KEY   = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] ENC   = 128'h69C4E0D86A7B0430D8CDB78070B4C55A;
    localparam logic [127:0] PLAIN = 128'h00112233445566778899AABBCCDDEEFF;

    int n_checks = 0;
    int n_fail   = 0;

    aes_avalon_regs dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .AVL_CS        (AVL_CS),
        .AVL_READ      (AVL_READ),
        .AVL_WRITE     (AVL_WRITE),
        .AVL_ADDR      (AVL_ADDR),
        .AVL_BYTE_EN   (AVL_BYTE_EN),
        .AVL_WRITEDATA (AVL_WRITEDATA),
        .AVL_READDATA  (AVL_READDATA),
        .EXPORT_DATA   (EXPORT_DATA),
        .AES_KEY       (AES_KEY),
        .AES_MSG_ENC   (AES_MSG_ENC),
        .AES_START     (AES_START),
        .AES_DONE      (AES_DONE),
        .AES_MSG_DEC   (AES_MSG_DEC)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic xfer(input logic rd, input logic wr, input logic [3:0] a,
                        input logic [31:0] d, input logic [3:0] be);
        @(negedge CLK);
        AVL_CS        = 1'b1;
        AVL_READ      = rd;
        AVL_WRITE     = wr;
        AVL_ADDR      = a;
        AVL_WRITEDATA = d;
        AVL_BYTE_EN   = be;
        @(posedge CLK);
        #1;
        AVL_CS    = 1'b0;
        AVL_READ  = 1'b0;
        AVL_WRITE = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        xfer(1'b0, 1'b1, a, d, be);
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
        xfer(1'b1, 1'b0, a, 32'h0, 4'h0);
        check(tag, AVL_READDATA, exp);
    endtask

    task automatic rd_all_zero(input string tag);
        for (int i = 0; i < 16; i++) begin
            rd_chk($sformatf("%s_r%0d", tag, i), 4'(i), 32'h0);
        end
    endtask

    // Start, two locked writes, then the core raises done on the edge of a third locked write: 3 RUN edges.
    task automatic do_run(input string tag);
        wr(4'd14, 32'h1, 4'hF);
        check({tag, "_start_rise"}, AES_START, 1'b1);
        wr(4'd0, 32'hFFFF_FFFF, 4'hF);
        check({tag, "_key_locked0"}, AES_KEY, KEY);
        wr(4'd14, 32'h0, 4'h1);
        check({tag, "_start_held"}, AES_START, 1'b1);
        AES_DONE    = 1'b1;
        AES_MSG_DEC = PLAIN;
        wr(4'd1, 32'hFFFF_FFFF, 4'hF);
        check({tag, "_key_locked1"}, AES_KEY, KEY);
        check({tag, "_start_done"}, AES_START, 1'b1);
    endtask

    initial begin
        RESET         = 1'b1;
        AVL_CS        = 1'b0;
        AVL_READ      = 1'b0;
        AVL_WRITE     = 1'b0;
        AVL_ADDR      = 4'h0;
        AVL_BYTE_EN   = 4'h0;
        AVL_WRITEDATA = 32'h0;
        AES_DONE      = 1'b0;
        AES_MSG_DEC   = 128'h0;

        repeat (2) @(posedge CLK);
        #1;
        check("rst_start", AES_START, 1'b0);
        check("rst_export", EXPORT_DATA, 32'h0);
        check("rst_key", AES_KEY, 128'h0);
        check("rst_rdata", AVL_READDATA, 32'h0);
        @(negedge CLK);
        RESET = 1'b0;
        rd_all_zero("rst");

        // Byte enables, read-only registers
        wr(4'd12, 32'h1234_5678, 4'b0101);
        rd_chk("scratch_be", 4'd12, 32'h0034_0078);
        wr(4'd9, 32'hDEAD_BEEF, 4'hF);
        rd_chk("ro_dec", 4'd9, 32'h0);
        wr(4'd13, 32'hDEAD_BEEF, 4'hF);
        rd_chk("ro_count", 4'd13, 32'h0);
        wr(4'd15, 32'hFFFF_FFFF, 4'hF);
        rd_chk("ro_status", 4'd15, 32'h0);

        // Same-edge read/write returns old value; read data holds with no read
        xfer(1'b1, 1'b1, 4'd12, 32'hAABB_CCDD, 4'hF);
        check("rw_old", AVL_READDATA, 32'h0034_0078);
        @(posedge CLK);
        #1;
        check("rdata_hold", AVL_READDATA, 32'h0034_0078);
        rd_chk("rw_new", 4'd12, 32'hAABB_CCDD);

        // Start write with byte 0 disabled does nothing
        wr(4'd14, 32'h0000_0001, 4'b1110);
        check("nostart_be", AES_START, 1'b0);
        rd_chk("nostart_reg14", 4'd14, 32'h0);

        wr(4'd0, 32'h0001_0203, 4'hF);
        wr(4'd1, 32'h0405_0607, 4'hF);
        wr(4'd2, 32'h0809_0A0B, 4'hF);
        wr(4'd3, 32'h0C0D_0E0F, 4'hF);
        wr(4'd4, 32'h69C4_E0D8, 4'hF);
        wr(4'd5, 32'h6A7B_0430, 4'hF);
        wr(4'd6, 32'hD8CD_B780, 4'hF);
        wr(4'd7, 32'h70B4_C55A, 4'hF);
        check("key_out", AES_KEY, KEY);
        check("enc_out", AES_MSG_ENC, ENC);
        check("export", EXPORT_DATA, 32'h0001_0E0F);
        check("idle_start", AES_START, 1'b0);

        do_run("run1");
        rd_chk("run1_status", 4'd15, 32'h1);
        rd_chk("run1_dec0", 4'd8, 32'h0011_2233);
        rd_chk("run1_dec1", 4'd9, 32'h4455_6677);
        rd_chk("run1_dec2", 4'd10, 32'h8899_AABB);
        rd_chk("run1_dec3", 4'd11, 32'hCCDD_EEFF);
        rd_chk("run1_count", 4'd13, 32'd3);
        rd_chk("run1_reg14", 4'd14, 32'h1);
        rd_chk("run1_key0", 4'd0, 32'h0001_0203);

        // Release from DONE; done held high by the core is ignored in IDLE
        wr(4'd14, 32'h0, 4'hF);
        check("stop_start", AES_START, 1'b0);
        rd_chk("stop_status", 4'd15, 32'h0);
        rd_chk("stop_reg14", 4'd14, 32'h0);
        rd_chk("stop_dec0", 4'd8, 32'h0011_2233);
        rd_chk("stop_dec3", 4'd11, 32'hCCDD_EEFF);
        rd_chk("stop_count", 4'd13, 32'd3);
        rd_chk("idle_done_ign", 4'd15, 32'h0);
        check("idle_done_start", AES_START, 1'b0);
        AES_DONE    = 1'b0;
        AES_MSG_DEC = 128'h0;

        do_run("run2");
        rd_chk("run2_status", 4'd15, 32'h1);
        rd_chk("run2_count", 4'd13, 32'd3);
        rd_chk("run2_dec1", 4'd9, 32'h4455_6677);
        wr(4'd14, 32'h0, 4'h1);
        check("run2_stop", AES_START, 1'b0);
        AES_DONE    = 1'b0;
        AES_MSG_DEC = 128'h0;

        // Asynchronous reset mid-RUN
        wr(4'd14, 32'h1, 4'hF);
        check("run3_start", AES_START, 1'b1);
        @(negedge CLK);
        #2;
        RESET = 1'b1;
        #1;
        check("arst_start", AES_START, 1'b0);
        check("arst_key", AES_KEY, 128'h0);
        check("arst_enc", AES_MSG_ENC, 128'h0);
        check("arst_export", EXPORT_DATA, 32'h0);
        check("arst_rdata", AVL_READDATA, 32'h0);
        @(negedge CLK);
        RESET = 1'b0;
        rd_all_zero("arst");
        check("arst_idle", AES_START, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_avalon_regs.md
# aes_avalon_regs

Avalon-MM slave register bank sitting directly upstream of the AES decryption core. It holds the 128-bit key and ciphertext written by the NIOS II and drives the core's start handshake. When the core reports done, it captures the decrypted message and exposes status and a cycle count back to software.

## Interface

Parameters:
- None. The map is fixed at 16 × 32-bit words.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- AVL_CS  in  1  chip select; reads and writes take effect only when this is high.
- AVL_READ  in  1  read strobe.
- AVL_WRITE  in  1  write strobe.
- AVL_ADDR  in  4  word address, 0–15.
- AVL_BYTE_EN  in  4  write byte enables; bit i enables byte [8i+7:8i].
- AVL_WRITEDATA  in  32  write data.
- AVL_READDATA  out  32  registered read data.
- EXPORT_DATA  out  32  {reg0[31:16], reg3[15:0]}, used for the hex display.
- AES_KEY  out  128  {reg0, reg1, reg2, reg3}; reg0 is the most significant word.
- AES_MSG_ENC  out  128  {reg4, reg5, reg6, reg7}.
- AES_START  out  1  start request to the core.
- AES_DONE  in  1  done flag from the core.
- AES_MSG_DEC  in  128  decrypted result from the core.

## Operation

Register map:
- 0–3: key. Read/write.
- 4–7: ciphertext. Read/write.
- 8–11: plaintext capture. Read-only; Avalon writes are ignored.
- 12: scratch. Read/write.
- 13: cycle count. Read-only.
- 14: START. Read/write; only bit 0 has effect, but all 32 bits are stored.
- 15: STATUS. Read-only; reads {31'b0, done_flag}.

Write rule:
- When AVL_CS & AVL_WRITE are high, each enabled byte of the addressed writable register is updated; unenabled bytes hold.
- Reads are side-effect free.

State machine (IDLE, RUN, DONE):
- IDLE: AES_START = 0.
  - A write to reg 14 with AVL_BYTE_EN[0] = 1 and AVL_WRITEDATA[0] = 1 moves to RUN and clears reg 13 on the same edge.
  - A write to reg 14 with data bit 0 = 0 stays in IDLE.
- RUN: AES_START = 1.
  - Writes to regs 0–7 and 14 are ignored (inputs locked). Reg 12 stays writable.
  - Reg 13 increments every edge spent in RUN, including the exit edge, and saturates at 0xFFFFFFFF.
  - On an edge with AES_DONE = 1: reg8..reg11 ← AES_MSG_DEC[127:96]..[31:0], done_flag ← 1, next state DONE.
- DONE: AES_START = 1, so the core holds its result.
  - A write to reg 14 that clears bit 0 (byte 0 enabled) moves to IDLE and clears done_flag on the same edge.
  - Regs 8–11 and 13 retain their values until the next run.
- No abort path: software cannot drop AES_START during RUN.
- AES_START is decoded from the state register (RUN or DONE) and is glitch-free.

Reset (asynchronous):
- All 16 registers, done_flag and AVL_READDATA go to 0.
- State goes to IDLE, so AES_START = 0.
- EXPORT_DATA, AES_KEY and AES_MSG_ENC go to 0.
- Reset asserted mid-RUN drops AES_START immediately. The core is reset by the same RESET.

## Timing

- Write latency: data written at edge k is visible on AES_KEY, AES_MSG_ENC and EXPORT_DATA after edge k.
- Read latency: 1 cycle. With AVL_CS & AVL_READ sampled at edge k, AVL_READDATA is valid after edge k and holds until the next read. When there is no read, AVL_READDATA holds its last value.
- Read and write of the same address on the same edge: the read returns the old value.
- Start: the START write at edge k makes AES_START high after edge k.
- Done: AES_DONE high at edge j captures the result at j. A read of reg 15 issued at edge j+1 returns 1.
- Same-edge conflicts:
  - AES_DONE arriving on the same edge as a locked write: the write is dropped and the capture proceeds.
  - AES_DONE seen while in IDLE or DONE: ignored.
- Counter: reg 13 after a run equals the number of RUN edges, including the exit edge.

## Test plan

1. Reset, then read all 16 addresses -> every read returns 0x00000000; AES_START = 0; EXPORT_DATA = 0.
2. Write 0x12345678 to reg 12 with AVL_BYTE_EN = 4'b0101, then read reg 12 -> 0x00340078. Write 0xDEADBEEF to reg 9 -> reads back 0.
3. Write key regs 0–3 = 00010203/04050607/08090A0B/0C0D0E0F and ciphertext regs 4–7 = 69C4E0D8/6A7B0430/D8CDB780/70B4C55A, then write reg 14 = 1 -> AES_START rises the next cycle. When AES_DONE is seen, regs 8–11 = 00112233/44556677/8899AABB/CCDDEEFF, reg 15 = 1, reg 13 = RUN edge count (nonzero). Check against a bench model of the core.
4. During RUN, write reg 0 = 0xFFFFFFFF and reg 14 = 0 -> both are ignored; AES_KEY is unchanged; AES_START stays 1 until DONE.
5. In DONE, write reg 14 = 0 -> AES_START falls after that edge and reg 15 reads 0; regs 8–11 still hold the plaintext. A second run with the same inputs reproduces an identical reg 13 value.
6. Assert RESET asynchronously mid-RUN, between clock edges -> AES_START falls before the next edge; all registers read 0 after deassertion; state is IDLE.
